// File: rtl/fft16_core.sv
// ---------------------------------------------------------------------------
// fft16_core
//   16-point radix-2 decimation-in-time FFT on signed fixed-point complex
//   samples. A free-running 5-step counter sequences each transform:
//     cnt=0 : capture all 16 inputs into the working array (bit-reversed)
//     cnt=1..4 : one butterfly stage per clock (span 1,2,4,8)
//   On the cnt=4 edge, the final stage is written to the outK registers and
//   o_FFT_cycle_done pulses for one cycle. No per-stage scaling is applied
//   (gain of 16), and add/sub results wrap modulo 2^N.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            asynchronous active-low reset
//   inK_re/inK_im    time sample K (K=0..15), two's complement, N bits
//   outK_re/outK_im  frequency bin K, natural order, registered
//   o_FFT_cycle_done one-cycle pulse: outK have just been updated
//   i_bin_addr       bin index for the read port
//   o_bin_data       {out[i_bin_addr]_re, out[i_bin_addr]_im}, 1-clock latency
// ---------------------------------------------------------------------------
module fft16_core #(
    parameter int N      = 16,
    parameter int Q      = 8,
    parameter int STAGES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N-1:0]        in0_re,  in0_im,  in1_re,  in1_im,
    input  logic [N-1:0]        in2_re,  in2_im,  in3_re,  in3_im,
    input  logic [N-1:0]        in4_re,  in4_im,  in5_re,  in5_im,
    input  logic [N-1:0]        in6_re,  in6_im,  in7_re,  in7_im,
    input  logic [N-1:0]        in8_re,  in8_im,  in9_re,  in9_im,
    input  logic [N-1:0]        in10_re, in10_im, in11_re, in11_im,
    input  logic [N-1:0]        in12_re, in12_im, in13_re, in13_im,
    input  logic [N-1:0]        in14_re, in14_im, in15_re, in15_im,
    output logic [N-1:0]        out0_re,  out0_im,  out1_re,  out1_im,
    output logic [N-1:0]        out2_re,  out2_im,  out3_re,  out3_im,
    output logic [N-1:0]        out4_re,  out4_im,  out5_re,  out5_im,
    output logic [N-1:0]        out6_re,  out6_im,  out7_re,  out7_im,
    output logic [N-1:0]        out8_re,  out8_im,  out9_re,  out9_im,
    output logic [N-1:0]        out10_re, out10_im, out11_re, out11_im,
    output logic [N-1:0]        out12_re, out12_im, out13_re, out13_im,
    output logic [N-1:0]        out14_re, out14_im, out15_re, out15_im,
    output logic                o_FFT_cycle_done,
    input  logic [STAGES-1:0]   i_bin_addr,
    output logic [2*N-1:0]      o_bin_data
);

    // ---------------------------------------------------------------------
    // Twiddles W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), in Q8 (1.0 = 256).
    // Only k = 0..7 are ever needed by a 16-point DIT.
    // ---------------------------------------------------------------------
    function automatic logic signed [N-1:0] tw_re(input logic [2:0] k);
        case (k)
            3'd0: tw_re = N'(256);
            3'd1: tw_re = N'(237);
            3'd2: tw_re = N'(181);
            3'd3: tw_re = N'(98);
            3'd4: tw_re = N'(0);
            3'd5: tw_re = N'(-98);
            3'd6: tw_re = N'(-181);
            3'd7: tw_re = N'(-237);
        endcase
    endfunction

    function automatic logic signed [N-1:0] tw_im(input logic [2:0] k);
        case (k)
            3'd0: tw_im = N'(0);
            3'd1: tw_im = N'(-98);
            3'd2: tw_im = N'(-181);
            3'd3: tw_im = N'(-237);
            3'd4: tw_im = N'(-256);
            3'd5: tw_im = N'(-237);
            3'd6: tw_im = N'(-181);
            3'd7: tw_im = N'(-98);
        endcase
    endfunction

    // Butterfly p (0..7) of stage s: top index a = g + j where h = 2^s,
    // j = p mod h and g = (p div h) * 2h. This is p with a zero inserted at
    // bit position s. The bottom index sets bit s. Twiddle index j*(8/h).
    function automatic logic [3:0] idx_top(input logic [1:0] s, input logic [2:0] p);
        case (s)
            2'd0: idx_top = {p, 1'b0};
            2'd1: idx_top = {p[2:1], 1'b0, p[0]};
            2'd2: idx_top = {p[2], 1'b0, p[1:0]};
            2'd3: idx_top = {1'b0, p};
        endcase
    endfunction

    function automatic logic [2:0] tw_idx(input logic [1:0] s, input logic [2:0] p);
        case (s)
            2'd0: tw_idx = 3'd0;
            2'd1: tw_idx = {p[0], 2'b00};
            2'd2: tw_idx = {p[1:0], 1'b0};
            2'd3: tw_idx = p;
        endcase
    endfunction

    function automatic logic [3:0] bitrev4(input logic [3:0] k);
        bitrev4 = {k[0], k[1], k[2], k[3]};
    endfunction

    // ---------------------------------------------------------------------
    // Input / output packing
    // ---------------------------------------------------------------------
    logic signed [N-1:0] in_re [16];
    logic signed [N-1:0] in_im [16];
    logic signed [N-1:0] out_re [16];
    logic signed [N-1:0] out_im [16];

    assign in_re[0]  = in0_re;  assign in_im[0]  = in0_im;
    assign in_re[1]  = in1_re;  assign in_im[1]  = in1_im;
    assign in_re[2]  = in2_re;  assign in_im[2]  = in2_im;
    assign in_re[3]  = in3_re;  assign in_im[3]  = in3_im;
    assign in_re[4]  = in4_re;  assign in_im[4]  = in4_im;
    assign in_re[5]  = in5_re;  assign in_im[5]  = in5_im;
    assign in_re[6]  = in6_re;  assign in_im[6]  = in6_im;
    assign in_re[7]  = in7_re;  assign in_im[7]  = in7_im;
    assign in_re[8]  = in8_re;  assign in_im[8]  = in8_im;
    assign in_re[9]  = in9_re;  assign in_im[9]  = in9_im;
    assign in_re[10] = in10_re; assign in_im[10] = in10_im;
    assign in_re[11] = in11_re; assign in_im[11] = in11_im;
    assign in_re[12] = in12_re; assign in_im[12] = in12_im;
    assign in_re[13] = in13_re; assign in_im[13] = in13_im;
    assign in_re[14] = in14_re; assign in_im[14] = in14_im;
    assign in_re[15] = in15_re; assign in_im[15] = in15_im;

    assign out0_re  = out_re[0];  assign out0_im  = out_im[0];
    assign out1_re  = out_re[1];  assign out1_im  = out_im[1];
    assign out2_re  = out_re[2];  assign out2_im  = out_im[2];
    assign out3_re  = out_re[3];  assign out3_im  = out_im[3];
    assign out4_re  = out_re[4];  assign out4_im  = out_im[4];
    assign out5_re  = out_re[5];  assign out5_im  = out_im[5];
    assign out6_re  = out_re[6];  assign out6_im  = out_im[6];
    assign out7_re  = out_re[7];  assign out7_im  = out_im[7];
    assign out8_re  = out_re[8];  assign out8_im  = out_im[8];
    assign out9_re  = out_re[9];  assign out9_im  = out_im[9];
    assign out10_re = out_re[10]; assign out10_im = out_im[10];
    assign out11_re = out_re[11]; assign out11_im = out_im[11];
    assign out12_re = out_re[12]; assign out12_im = out_im[12];
    assign out13_re = out_re[13]; assign out13_im = out_im[13];
    assign out14_re = out_re[14]; assign out14_im = out_im[14];
    assign out15_re = out_re[15]; assign out15_im = out_im[15];

    // ---------------------------------------------------------------------
    // Step counter and working array
    // ---------------------------------------------------------------------
    logic [2:0]          cnt;
    logic [1:0]          stage;
    logic signed [N-1:0] w_re [16];
    logic signed [N-1:0] w_im [16];

    // cnt 1..4 map to stages 0..3 (cnt=4 wraps to 3 through the 2-bit subtract).
    assign stage = cnt[1:0] - 2'd1;

    // ---------------------------------------------------------------------
    // One butterfly stage, selected by 'stage'
    // ---------------------------------------------------------------------
    logic [3:0]              ia [8];
    logic [3:0]              ib [8];
    logic [2:0]              kk [8];
    logic signed [2*N-1:0]   pr_re [8];
    logic signed [2*N-1:0]   pr_im [8];
    logic signed [N-1:0]     t_re [8];
    logic signed [N-1:0]     t_im [8];
    logic signed [N-1:0]     nxt_re [16];
    logic signed [N-1:0]     nxt_im [16];

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            nxt_re[k] = w_re[k];
            nxt_im[k] = w_im[k];
        end
        for (int p = 0; p < 8; p++) begin
            ia[p] = idx_top(stage, 3'(p));
            ib[p] = ia[p] | (4'd1 << stage);
            kk[p] = tw_idx(stage, 3'(p));
            // Full-width products; the arithmetic shift floors, then truncate.
            pr_re[p] = (2*N)'(w_re[ib[p]]) * (2*N)'(tw_re(kk[p]))
                     - (2*N)'(w_im[ib[p]]) * (2*N)'(tw_im(kk[p]));
            pr_im[p] = (2*N)'(w_re[ib[p]]) * (2*N)'(tw_im(kk[p]))
                     + (2*N)'(w_im[ib[p]]) * (2*N)'(tw_re(kk[p]));
            t_re[p]  = N'(pr_re[p] >>> Q);
            t_im[p]  = N'(pr_im[p] >>> Q);
            nxt_re[ia[p]] = w_re[ia[p]] + t_re[p];
            nxt_im[ia[p]] = w_im[ia[p]] + t_im[p];
            nxt_re[ib[p]] = w_re[ia[p]] - t_re[p];
            nxt_im[ib[p]] = w_im[ia[p]] - t_im[p];
        end
    end

    // ---------------------------------------------------------------------
    // Sequencing, output registers and read port
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt              <= 3'd0;
            o_FFT_cycle_done <= 1'b0;
            o_bin_data       <= '0;
            for (int k = 0; k < 16; k++) begin
                w_re[k]   <= '0;
                w_im[k]   <= '0;
                out_re[k] <= '0;
                out_im[k] <= '0;
            end
        end else begin
            o_FFT_cycle_done <= 1'b0;
            // Reads the outK value from before this edge.
            o_bin_data <= {out_re[i_bin_addr], out_im[i_bin_addr]};
            case (cnt)
                3'd0: begin
                    for (int k = 0; k < 16; k++) begin
                        w_re[bitrev4(4'(k))] <= in_re[k];
                        w_im[bitrev4(4'(k))] <= in_im[k];
                    end
                    cnt <= 3'd1;
                end
                3'd4: begin
                    for (int k = 0; k < 16; k++) begin
                        w_re[k]   <= nxt_re[k];
                        w_im[k]   <= nxt_im[k];
                        out_re[k] <= nxt_re[k];
                        out_im[k] <= nxt_im[k];
                    end
                    o_FFT_cycle_done <= 1'b1;
                    cnt              <= 3'd0;
                end
                default: begin
                    for (int k = 0; k < 16; k++) begin
                        w_re[k] <= nxt_re[k];
                        w_im[k] <= nxt_im[k];
                    end
                    cnt <= cnt + 3'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft16_core.sv
module tb_fft16_core;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [15:0] in_re [16];
    logic [15:0] in_im [16];
    logic [15:0] o_re [16];
    logic [15:0] o_im [16];
    logic        o_done;
    logic [3:0]  i_bin_addr = 4'd0;
    logic [31:0] o_bin_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Hand-derived spectrum of a 256 impulse at sample 1: bins 0..7 = W16^k*256,
    // bins 8..15 = -W16^(k-8)*256.
    int imp1_re [16] = '{256, 237, 181, 98, 0, -98, -181, -237,
                         -256, -237, -181, -98, 0, 98, 181, 237};
    int imp1_im [16] = '{0, -98, -181, -237, -256, -237, -181, -98,
                         0, 98, 181, 237, 256, 237, 181, 98};

    always #5 i_clk = ~i_clk;

    fft16_core dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .in0_re(in_re[0]),   .in0_im(in_im[0]),   .in1_re(in_re[1]),   .in1_im(in_im[1]),
        .in2_re(in_re[2]),   .in2_im(in_im[2]),   .in3_re(in_re[3]),   .in3_im(in_im[3]),
        .in4_re(in_re[4]),   .in4_im(in_im[4]),   .in5_re(in_re[5]),   .in5_im(in_im[5]),
        .in6_re(in_re[6]),   .in6_im(in_im[6]),   .in7_re(in_re[7]),   .in7_im(in_im[7]),
        .in8_re(in_re[8]),   .in8_im(in_im[8]),   .in9_re(in_re[9]),   .in9_im(in_im[9]),
        .in10_re(in_re[10]), .in10_im(in_im[10]), .in11_re(in_re[11]), .in11_im(in_im[11]),
        .in12_re(in_re[12]), .in12_im(in_im[12]), .in13_re(in_re[13]), .in13_im(in_im[13]),
        .in14_re(in_re[14]), .in14_im(in_im[14]), .in15_re(in_re[15]), .in15_im(in_im[15]),
        .out0_re(o_re[0]),   .out0_im(o_im[0]),   .out1_re(o_re[1]),   .out1_im(o_im[1]),
        .out2_re(o_re[2]),   .out2_im(o_im[2]),   .out3_re(o_re[3]),   .out3_im(o_im[3]),
        .out4_re(o_re[4]),   .out4_im(o_im[4]),   .out5_re(o_re[5]),   .out5_im(o_im[5]),
        .out6_re(o_re[6]),   .out6_im(o_im[6]),   .out7_re(o_re[7]),   .out7_im(o_im[7]),
        .out8_re(o_re[8]),   .out8_im(o_im[8]),   .out9_re(o_re[9]),   .out9_im(o_im[9]),
        .out10_re(o_re[10]), .out10_im(o_im[10]), .out11_re(o_re[11]), .out11_im(o_im[11]),
        .out12_re(o_re[12]), .out12_im(o_im[12]), .out13_re(o_re[13]), .out13_im(o_im[13]),
        .out14_re(o_re[14]), .out14_im(o_im[14]), .out15_re(o_re[15]), .out15_im(o_im[15]),
        .o_FFT_cycle_done(o_done),
        .i_bin_addr(i_bin_addr),
        .o_bin_data(o_bin_data)
    );

    task automatic clear_inputs();
        for (int k = 0; k < 16; k++) begin
            in_re[k] = 16'd0;
            in_im[k] = 16'd0;
        end
    endtask

    // Returns #1 after the first edge on which done is seen; the next edge is a load.
    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(posedge i_clk);
            #1;
            if (o_done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            total_cnt++;
            $display("FAIL %s_timeout: done=0 required 1 within 12 cycles", tag);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            total_cnt++;
            if (o_re[k] !== 16'd0 || o_im[k] !== 16'd0)
                $display("FAIL reset_out%0d: got (%0d,%0d) required (0,0)", k,
                         $signed(o_re[k]), $signed(o_im[k]));
            else pass_cnt++;
        end
        total_cnt++;
        if (o_done !== 1'b0 || o_bin_data !== 32'd0)
            $display("FAIL reset_ctrl: done=%b bin=%h required 0/00000000", o_done, o_bin_data);
        else pass_cnt++;
        @(negedge i_clk);
        i_rst = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge i_clk);
            #1;
            total_cnt++;
            if (o_done !== ((e == 5 || e == 10) ? 1'b1 : 1'b0))
                $display("FAIL done_edge%0d: got %b required %b", e, o_done,
                         (e == 5 || e == 10));
            else pass_cnt++;
            if (e == 5) begin
                for (int k = 0; k < 16; k++) begin
                    total_cnt++;
                    if (o_re[k] !== 16'd0 || o_im[k] !== 16'd0)
                        $display("FAIL zero_out%0d: got (%0d,%0d) required (0,0)", k,
                                 $signed(o_re[k]), $signed(o_im[k]));
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_impulse0();
        wait_done("imp0_sync");
        clear_inputs();
        in_re[0] = 16'd256;
        wait_done("imp0");
        for (int k = 0; k < 16; k++) begin
            total_cnt++;
            if (o_re[k] !== 16'd256 || o_im[k] !== 16'd0)
                $display("FAIL imp0_out%0d: got (%0d,%0d) required (256,0)", k,
                         $signed(o_re[k]), $signed(o_im[k]));
            else pass_cnt++;
        end
    endtask

    task automatic test_dc();
        wait_done("dc_sync");
        clear_inputs();
        for (int k = 0; k < 16; k++) in_re[k] = 16'd256;
        wait_done("dc");
        for (int k = 0; k < 16; k++) begin
            total_cnt++;
            if (o_re[k] !== ((k == 0) ? 16'd4096 : 16'd0) || o_im[k] !== 16'd0)
                $display("FAIL dc_out%0d: got (%0d,%0d) required (%0d,0)", k,
                         $signed(o_re[k]), $signed(o_im[k]), (k == 0) ? 4096 : 0);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_change();
        int exp_re [8] = '{512, 437, 256, 75, 0, 75, 256, 437};
        int exp_im [8] = '{0, -181, -256, -181, 0, 181, 256, 181};
        wait_done("mid_sync");
        clear_inputs();
        in_re[0] = 16'd256;
        @(posedge i_clk); #1;   // load edge
        @(posedge i_clk); #1;   // cnt is now 2
        in_re[2] = 16'd256;
        wait_done("mid_cur");
        for (int k = 0; k < 16; k++) begin
            total_cnt++;
            if (o_re[k] !== 16'd256 || o_im[k] !== 16'd0)
                $display("FAIL mid_cur_out%0d: got (%0d,%0d) required (256,0)", k,
                         $signed(o_re[k]), $signed(o_im[k]));
            else pass_cnt++;
        end
        // Next transform sees impulse(0)+impulse(2): 256 + 256*W16^(2k), period 8.
        wait_done("mid_next");
        for (int k = 0; k < 16; k++) begin
            total_cnt++;
            if (o_re[k] !== 16'(exp_re[k % 8]) || o_im[k] !== 16'(exp_im[k % 8]))
                $display("FAIL mid_next_out%0d: got (%0d,%0d) required (%0d,%0d)", k,
                         $signed(o_re[k]), $signed(o_im[k]), exp_re[k % 8], exp_im[k % 8]);
            else pass_cnt++;
        end
    endtask

    task automatic test_impulse1();
        wait_done("imp1_sync");
        clear_inputs();
        in_re[1] = 16'd256;
        wait_done("imp1");
        for (int k = 0; k < 16; k++) begin
            total_cnt++;
            if (o_re[k] !== 16'(imp1_re[k]) || o_im[k] !== 16'(imp1_im[k]))
                $display("FAIL imp1_out%0d: got (%0d,%0d) required (%0d,%0d)", k,
                         $signed(o_re[k]), $signed(o_im[k]), imp1_re[k], imp1_im[k]);
            else pass_cnt++;
        end
    endtask

    // Inputs stay at impulse(1), so outK keep the same values through reloads.
    task automatic test_bin_read();
        logic [31:0] exp_word;
        for (int k = 0; k < 16; k++) begin
            @(negedge i_clk);
            i_bin_addr = 4'(k);
            @(posedge i_clk);
            #1;
            exp_word = {16'(imp1_re[k]), 16'(imp1_im[k])};
            total_cnt++;
            if (o_bin_data !== exp_word)
                $display("FAIL bin_read%0d: got %h required %h", k, o_bin_data, exp_word);
            else pass_cnt++;
            if (k == 4) begin
                total_cnt++;
                if (o_bin_data !== 32'h0000_FF00)
                    $display("FAIL bin_read4_word: got %h required 0000ff00", o_bin_data);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_done("rst_sync");
        repeat (3) begin
            @(posedge i_clk);
            #1;
        end
        // cnt is now 3
        i_rst = 1'b0;
        #1;
        for (int k = 0; k < 16; k++) begin
            total_cnt++;
            if (o_re[k] !== 16'd0 || o_im[k] !== 16'd0)
                $display("FAIL rstmid_out%0d: got (%0d,%0d) required (0,0)", k,
                         $signed(o_re[k]), $signed(o_im[k]));
            else pass_cnt++;
        end
        total_cnt++;
        if (o_done !== 1'b0 || o_bin_data !== 32'd0)
            $display("FAIL rstmid_ctrl: done=%b bin=%h required 0/00000000", o_done, o_bin_data);
        else pass_cnt++;
        @(negedge i_clk);
        i_rst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge i_clk);
            #1;
            total_cnt++;
            if (o_done !== ((e == 5) ? 1'b1 : 1'b0))
                $display("FAIL rstmid_done_edge%0d: got %b required %b", e, o_done, (e == 5));
            else pass_cnt++;
        end
        total_cnt++;
        if (o_re[1] !== 16'd237 || o_im[1] !== 16'hFF9E)
            $display("FAIL rstmid_out1: got (%0d,%0d) required (237,-98)",
                     $signed(o_re[1]), $signed(o_im[1]));
        else pass_cnt++;
        total_cnt++;
        if (o_re[8] !== 16'hFF00 || o_im[8] !== 16'd0)
            $display("FAIL rstmid_out8: got (%0d,%0d) required (-256,0)",
                     $signed(o_re[8]), $signed(o_im[8]));
        else pass_cnt++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_impulse0();
        test_dc();
        test_mid_change();
        test_impulse1();
        test_bin_read();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
